// File: rtl/seq_right_shifter.sv
// seq_right_shifter: iterative right shifter (SRL/SRA, optional ROR), one bit
// position per clock, with a start/busy/done handshake for the EX-stage shift path.
// Optional feature macro: SHIFTER_ROTATE_EN (op=10 rotates right; otherwise SRL).
module seq_right_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [1:0] OP_SRA = 2'b01;
`ifdef SHIFTER_ROTATE_EN
  localparam logic [1:0] OP_ROR = 2'b10;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   work, work_n;
  logic [WIDTH-1:0]   result_n;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] count, count_n;
  logic [1:0]         op_q, op_n;
  logic               fill;

  // One-bit right shift of the working register with op-dependent fill bit
  always_comb begin
    fill = 1'b0;
    if (op_q == OP_SRA) fill = work[WIDTH-1];
`ifdef SHIFTER_ROTATE_EN
    if (op_q == OP_ROR) fill = work[0];
`endif
    shifted = (work >> 1) | {fill, {(WIDTH-1){1'b0}}};
  end

  // Next-state and datapath update; IDLE and DONE accept a new request identically
  always_comb begin
    state_n  = state;
    work_n   = work;
    count_n  = count;
    op_n     = op_q;
    result_n = result;
    case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE) state_n = S_IDLE;
        if (start) begin
          if (shamt != '0) begin
            work_n  = data_in;
            op_n    = op;
            count_n = shamt;
            state_n = S_SHIFT;
          end else begin
            result_n = data_in;
            state_n  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        work_n  = shifted;
        count_n = count - SHAMT_W'(1);
        if (count == SHAMT_W'(1)) begin
          result_n = shifted;
          state_n  = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs; reset drops any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      work   <= '0;
      count  <= '0;
      op_q   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      count  <= count_n;
      op_q   <= op_n;
      result <= result_n;
      busy   <= (state_n == S_SHIFT);
      done   <= (state_n == S_DONE);
    end
  end

endmodule
